matrix_mult: RTL and testbench



---
 rtl/matrix_mult_pkg.sv | 15 +
 rtl/matrix_mult_dot3.sv | 19 +
 rtl/matrix_mult.sv | 91 +++++++++
 tb/tb_matrix_mult.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared sizes and types for the 3x3 sequential matrix multiplier.
package matrix_mult_pkg;
  localparam int N      = 3;
  localparam int NUM_EL = N * N;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;

  typedef logic [3:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;
endpackage

// File: rtl/matrix_mult_dot3.sv
// Combinational 3-term unsigned dot product; the sum is widened so it cannot overflow.
module matrix_mult_dot3
  import matrix_mult_pkg::*;
(
  input  logic [DATA_W-1:0] a [0:2],
  input  logic [DATA_W-1:0] b [0:2],
  output logic [ACC_W-1:0]  sum
);

  logic [2*DATA_W-1:0] p0;
  logic [2*DATA_W-1:0] p1;
  logic [2*DATA_W-1:0] p2;

  assign p0  = a[0] * b[0];
  assign p1  = a[1] * b[1];
  assign p2  = a[2] * b[2];
  assign sum = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2);

endmodule

// File: rtl/matrix_mult.sv
// Sequential 3x3 multiplier: captures A and B on an enable edge, then writes one
// element of C per clock through a single shared dot-product unit.
module matrix_mult
  import matrix_mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] A [0:NUM_EL-1],
  input  logic [DATA_W-1:0] B [0:NUM_EL-1],
  output logic [ACC_W-1:0]  C [0:NUM_EL-1],
  output logic              done
);

  state_t            state;
  idx_t              idx;
  logic              enable_q;
  logic [DATA_W-1:0] a_cap [0:NUM_EL-1];
  logic [DATA_W-1:0] b_cap [0:NUM_EL-1];

  logic [1:0]        row_sel;
  logic [1:0]        col_sel;
  idx_t              row_base;
  idx_t              col_base;
  logic [DATA_W-1:0] a_vec [0:2];
  logic [DATA_W-1:0] b_vec [0:2];
  logic [ACC_W-1:0]  dot;

  // Row of A and column of B for the element currently being produced.
  always_comb begin
    row_sel  = 2'(idx / 4'd3);
    col_sel  = 2'(idx % 4'd3);
    row_base = 4'(row_sel) * 4'd3;
    col_base = 4'(col_sel);
    a_vec[0] = a_cap[row_base];
    a_vec[1] = a_cap[row_base + 4'd1];
    a_vec[2] = a_cap[row_base + 4'd2];
    b_vec[0] = b_cap[col_base];
    b_vec[1] = b_cap[col_base + 4'd3];
    b_vec[2] = b_cap[col_base + 4'd6];
  end

  matrix_mult_dot3 u_dot3 (
    .a   (a_vec),
    .b   (b_vec),
    .sum (dot)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      enable_q <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < NUM_EL; i++) begin
        a_cap[i] <= '0;
        b_cap[i] <= '0;
        C[i]     <= '0;
      end
    end else begin
      enable_q <= enable;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !enable_q) begin
            a_cap <= A;
            b_cap <= B;
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          C[idx] <= dot;
          // idx wraps to 0 after the last element so the muxes never address past the array.
          if (idx == idx_t'(NUM_EL - 1)) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult.sv
// Directed self-checking bench for matrix_mult with hand-computed expected matrices.
module tb_matrix_mult;
  import matrix_mult_pkg::*;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [DATA_W-1:0] A [0:NUM_EL-1];
  logic [DATA_W-1:0] B [0:NUM_EL-1];
  logic [ACC_W-1:0]  C [0:NUM_EL-1];
  logic              done;

  int n_compared;
  int n_mismatched;

  logic [DATA_W-1:0] a_m [0:NUM_EL-1];
  logic [DATA_W-1:0] b_m [0:NUM_EL-1];
  logic [ACC_W-1:0]  exp_m [0:NUM_EL-1];

  matrix_mult dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .A      (A),
    .B      (B),
    .C      (C),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic checkMatrix(input string tag, input logic [ACC_W-1:0] exp_c [0:NUM_EL-1]);
    for (int i = 0; i < NUM_EL; i++)
      checkOutput($sformatf("%s_C%0d", tag, i), 32'(C[i]), 32'(exp_c[i]));
  endtask

  // Drives operands, pulses enable for one cycle and waits (bounded) for done.
  task automatic applyStimulus(input string tag, input logic [DATA_W-1:0] a [0:NUM_EL-1],
                               input logic [DATA_W-1:0] b [0:NUM_EL-1]);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    A      = a;
    B      = b;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < NUM_EL; i++) begin
      A[i] = 8'hA5;
      B[i] = 8'h5A;
    end
    for (int cyc = 2; cyc <= 11 && !seen; cyc++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen && done) seen = 1'b1;
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int pulses;
    n_compared   = 0;
    n_mismatched = 0;
    reset  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < NUM_EL; i++) begin
      A[i] = '0;
      B[i] = '0;
    end

    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_done", 32'(done), 32'd0);
    exp_m = '{default: '0};
    checkMatrix("reset", exp_m);

    a_m   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    b_m   = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    exp_m = '{18'd30, 18'd24, 18'd18, 18'd84, 18'd69, 18'd54, 18'd138, 18'd114, 18'd90};
    applyStimulus("basic", a_m, b_m);
    checkMatrix("basic", exp_m);

    a_m   = '{default: 8'd255};
    b_m   = '{default: 8'd255};
    exp_m = '{default: 18'd195075};
    applyStimulus("max", a_m, b_m);
    checkMatrix("max", exp_m);

    a_m   = '{default: 8'd1};
    b_m   = '{default: 8'd1};
    exp_m = '{default: 18'd3};
    applyStimulus("ones", a_m, b_m);
    checkMatrix("ones", exp_m);

    a_m   = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    b_m   = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13};
    exp_m = '{18'd5, 18'd6, 18'd7, 18'd8, 18'd9, 18'd10, 18'd11, 18'd12, 18'd13};
    applyStimulus("ident", a_m, b_m);
    checkMatrix("ident", exp_m);

    a_m   = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd4};
    b_m   = '{8'd5, 8'd0, 8'd0, 8'd0, 8'd6, 8'd0, 8'd0, 8'd0, 8'd7};
    exp_m = '{18'd10, 18'd0, 18'd0, 18'd0, 18'd18, 18'd0, 18'd0, 18'd0, 18'd28};
    applyStimulus("diag", a_m, b_m);
    checkMatrix("diag", exp_m);

    a_m    = '{default: 8'd0};
    b_m    = '{default: 8'd0};
    a_m[4] = 8'd10;
    b_m[4] = 8'd20;
    exp_m  = '{default: 18'd0};
    exp_m[4] = 18'd200;
    applyStimulus("center", a_m, b_m);
    checkMatrix("center", exp_m);

    // Abort a run two cycles in; reset must wipe C and done immediately.
    a_m = '{default: 8'd7};
    b_m = '{default: 8'd7};
    @(negedge clk);
    A      = a_m;
    B      = b_m;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midreset_done", 32'(done), 32'd0);
    exp_m = '{default: '0};
    checkMatrix("midreset", exp_m);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkMatrix("midreset_hold", exp_m);

    a_m   = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    b_m   = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    exp_m = '{18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8, 18'd9, 18'd10};
    applyStimulus("b2b_first", a_m, b_m);
    checkMatrix("b2b_first", exp_m);

    b_m   = '{8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    exp_m = '{18'd10, 18'd9, 18'd8, 18'd7, 18'd6, 18'd5, 18'd4, 18'd3, 18'd2};
    applyStimulus("b2b_second", a_m, b_m);
    checkMatrix("b2b_second", exp_m);

    // A level held high must start exactly one run.
    pulses = 0;
    @(negedge clk);
    A      = '{default: 8'd2};
    B      = '{default: 8'd3};
    enable = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 3) enable = 1'b0;
      if (done) pulses++;
    end
    checkOutput("held_pulses", 32'(pulses), 32'd1);
    exp_m = '{default: 18'd18};
    checkMatrix("held", exp_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
